// File: rtl/bf_pkg.sv
// Shared Brainfuck definitions: command bytes, loader state encoding
// and loader error codes. Used by the program loader and the CPU.
package bf_pkg;

  localparam logic [7:0] CMD_INC   = 8'h2B; // +
  localparam logic [7:0] CMD_DEC   = 8'h2D; // -
  localparam logic [7:0] CMD_LEFT  = 8'h3C; // <
  localparam logic [7:0] CMD_RIGHT = 8'h3E; // >
  localparam logic [7:0] CMD_OUT   = 8'h2E; // .
  localparam logic [7:0] CMD_IN    = 8'h2C; // ,
  localparam logic [7:0] CMD_JZ    = 8'h5B; // [
  localparam logic [7:0] CMD_JNZ   = 8'h5D; // ]

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIXUP,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CLOSE = 2'd1;
  localparam logic [1:0] ERR_OPEN  = 2'd2;
  localparam logic [1:0] ERR_OVF   = 2'd3;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_INC)   || (b == CMD_DEC) ||
           (b == CMD_LEFT)  || (b == CMD_RIGHT) ||
           (b == CMD_OUT)   || (b == CMD_IN) ||
           (b == CMD_JZ)    || (b == CMD_JNZ);
  endfunction

endpackage

// File: rtl/bf_bracket_stack.sv
// LIFO of open-bracket addresses. Ports: clk, rst_i (async, low),
// clr, push, pop, din -> top (valid same cycle), empty, full.
module bf_bracket_stack #(
  parameter int DW = 15,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] top,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   cnt;
  logic [AW-1:0] top_idx;

  assign empty   = (cnt == '0);
  assign full    = cnt[AW];
  assign top_idx = cnt[AW-1:0] - 1'b1;
  assign top     = mem[top_idx];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr)
      mem[cnt[AW-1:0]] <= din;
  end

endmodule

// File: rtl/brainfuck_prog_loader.sv
// Streams a Brainfuck program into instruction and jump-pointer RAMs,
// matching brackets on the fly. Ports: clk, rst_i (async, low), start,
// prog_data/valid/eof/ready byte stream, inst_* and jumpptr_* RAM write
// ports, prog_size, done, error, error_code.
// Build option: BF_LOADER_FILTER_EN drops non-command bytes.
module brainfuck_prog_loader
  import bf_pkg::*;
#(
  parameter int INST_ADDR_WIDTH  = 15,
  parameter int STACK_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       start,
  input  logic [7:0]                 prog_data,
  input  logic                       prog_valid,
  input  logic                       prog_eof,
  output logic                       prog_ready,
  output logic [INST_ADDR_WIDTH-1:0] inst_addr,
  output logic [7:0]                 inst_store_data,
  output logic                       inst_we,
  output logic [INST_ADDR_WIDTH-1:0] jumpptr_addr,
  output logic [INST_ADDR_WIDTH-1:0] jumpptr_store_data,
  output logic                       jumpptr_we,
  output logic [INST_ADDR_WIDTH:0]   prog_size,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 error_code
);

  localparam int IAW = INST_ADDR_WIDTH;

  state_t         state;
  logic [IAW:0]   wp;
  logic [IAW-1:0] wp_lo;
  logic [IAW-1:0] fix_addr;
  logic [IAW-1:0] fix_data;
  logic [IAW-1:0] top;
  logic           empty;
  logic           full;
  logic           keep;
  logic           is_open;
  logic           is_close;
  logic           can_start;
  logic           push;
  logic           pop;

`ifdef BF_LOADER_FILTER_EN
  assign keep = is_cmd(prog_data);
`else
  assign keep = 1'b1;
`endif

  assign wp_lo     = wp[IAW-1:0];
  assign is_open   = (prog_data == CMD_JZ);
  assign is_close  = (prog_data == CMD_JNZ);
  assign can_start = (state == ST_IDLE) || (state == ST_DONE) ||
                     (state == ST_ERROR);

  // wp[IAW] set means the RAM is already full.
  assign push = (state == ST_LOAD) && prog_valid && keep &&
                is_open && !wp[IAW] && !full;
  assign pop  = (state == ST_LOAD) && prog_valid && keep &&
                is_close && !wp[IAW] && !empty;

  bf_bracket_stack #(
    .DW (IAW),
    .AW (STACK_ADDR_WIDTH)
  ) u_stack (
    .clk   (clk),
    .rst_i (rst_i),
    .clr   (start && can_start),
    .push  (push),
    .pop   (pop),
    .din   (wp_lo),
    .top   (top),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state              <= ST_IDLE;
      wp                 <= '0;
      fix_addr           <= '0;
      fix_data           <= '0;
      prog_ready         <= 1'b0;
      inst_addr          <= '0;
      inst_store_data    <= '0;
      inst_we            <= 1'b0;
      jumpptr_addr       <= '0;
      jumpptr_store_data <= '0;
      jumpptr_we         <= 1'b0;
      prog_size          <= '0;
      done               <= 1'b0;
      error              <= 1'b0;
      error_code         <= ERR_NONE;
    end else begin
      inst_we    <= 1'b0;
      jumpptr_we <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state      <= ST_LOAD;
            prog_ready <= 1'b1;
            wp         <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            error_code <= ERR_NONE;
          end
        end
        ST_LOAD: begin
          if (prog_valid) begin
            if (keep) begin
              if (wp[IAW] || (is_open && full)) begin
                state      <= ST_ERROR;
                prog_ready <= 1'b0;
                error      <= 1'b1;
                error_code <= ERR_OVF;
              end else if (is_close && empty) begin
                state      <= ST_ERROR;
                prog_ready <= 1'b0;
                error      <= 1'b1;
                error_code <= ERR_CLOSE;
              end else begin
                inst_we         <= 1'b1;
                inst_addr       <= wp_lo;
                inst_store_data <= prog_data;
                wp              <= wp + 1'b1;
                if (is_close) begin
                  // ']' side now, matching '[' side next cycle.
                  jumpptr_we         <= 1'b1;
                  jumpptr_addr       <= wp_lo;
                  jumpptr_store_data <= top + 1'b1;
                  fix_addr           <= top;
                  fix_data           <= wp_lo + 1'b1;
                  state              <= ST_FIXUP;
                  prog_ready         <= 1'b0;
                end
              end
            end
          end else if (prog_eof) begin
            prog_ready <= 1'b0;
            if (!empty) begin
              state      <= ST_ERROR;
              error      <= 1'b1;
              error_code <= ERR_OPEN;
            end else begin
              state     <= ST_DONE;
              prog_size <= wp;
              done      <= 1'b1;
            end
          end
        end
        ST_FIXUP: begin
          jumpptr_we         <= 1'b1;
          jumpptr_addr       <= fix_addr;
          jumpptr_store_data <= fix_data;
          state              <= ST_LOAD;
          prog_ready         <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          prog_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
